// File: rtl/wasm_run_monitor.sv
// Run supervisor for WASM_TOP: counts RUN cycles from a start pulse to instruction finish,
// enforces a watchdog, captures the first error snapshot and keeps sticky end-of-run status.
module wasm_run_monitor #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 500,
    parameter int NUM_ERR        = 3,
    parameter int RUN_CNT_W      = 8,
    localparam int IDX_W         = (NUM_ERR > 1) ? $clog2(NUM_ERR) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_clear,
    input  logic                 i_instr_finish,
    input  logic [NUM_ERR-1:0]   i_err,
    output logic [2:0]           o_state,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_halt_req,
    output logic [CNT_W-1:0]     o_cycle_cnt,
    output logic [NUM_ERR-1:0]   o_err_vec,
    output logic [IDX_W-1:0]     o_err_idx,
    output logic [RUN_CNT_W-1:0] o_run_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DONE    = 3'd2,
        ST_FAULT   = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    localparam bit               WDOG_EN      = (TIMEOUT_CYCLES != 0);

    // Reject parameter sets the hardware cannot honour.
    if (NUM_ERR < 1) begin : g_bad_num_err
        $error("wasm_run_monitor: NUM_ERR must be at least 1");
    end
    if ((TIMEOUT_CYCLES < 0) || ((CNT_W < 31) && (TIMEOUT_CYCLES > ((2 ** CNT_W) - 1)))) begin : g_bad_timeout
        $error("wasm_run_monitor: TIMEOUT_CYCLES not representable in CNT_W bits");
    end

    state_t               state_r;
    logic [2:0]           flags_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [NUM_ERR-1:0]   err_vec_r;
    logic [IDX_W-1:0]     err_idx_r;
    logic [RUN_CNT_W-1:0] run_cnt_r;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_ERR-1:0] v);
        lowest_idx = {IDX_W{1'b0}};
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_idx = IDX_W'(i);
            end
        end
    endfunction

    // {busy, done, halt_req} for a given state, registered alongside the state itself.
    function automatic logic [2:0] state_flags(input state_t s);
        case (s)
            ST_RUN:     state_flags = 3'b100;
            ST_DONE:    state_flags = 3'b010;
            ST_FAULT:   state_flags = 3'b001;
            ST_TIMEOUT: state_flags = 3'b001;
            default:    state_flags = 3'b000;
        endcase
    endfunction

    // Run supervisor FSM with counters and error capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            flags_r   <= 3'b000;
            cnt_r     <= {CNT_W{1'b0}};
            err_vec_r <= {NUM_ERR{1'b0}};
            err_idx_r <= {IDX_W{1'b0}};
            run_cnt_r <= {RUN_CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!i_clear && i_start) begin
                        state_r <= ST_RUN;
                        flags_r <= state_flags(ST_RUN);
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (i_clear) begin
                        state_r <= ST_IDLE;
                        flags_r <= state_flags(ST_IDLE);
                        cnt_r   <= {CNT_W{1'b0}};
                    end else if (|i_err) begin
                        state_r   <= ST_FAULT;
                        flags_r   <= state_flags(ST_FAULT);
                        err_vec_r <= i_err;
                        err_idx_r <= lowest_idx(i_err);
                        run_cnt_r <= run_cnt_r + RUN_CNT_W'(1);
                    end else if (i_instr_finish) begin
                        state_r   <= ST_DONE;
                        flags_r   <= state_flags(ST_DONE);
                        run_cnt_r <= run_cnt_r + RUN_CNT_W'(1);
                    end else if (WDOG_EN && (cnt_r == TIMEOUT_LAST)) begin
                        state_r   <= ST_TIMEOUT;
                        flags_r   <= state_flags(ST_TIMEOUT);
                        run_cnt_r <= run_cnt_r + RUN_CNT_W'(1);
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE, ST_FAULT, ST_TIMEOUT: begin
                    if (i_clear) begin
                        state_r   <= ST_IDLE;
                        flags_r   <= state_flags(ST_IDLE);
                        cnt_r     <= {CNT_W{1'b0}};
                        err_vec_r <= {NUM_ERR{1'b0}};
                        err_idx_r <= {IDX_W{1'b0}};
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    flags_r   <= 3'b000;
                    cnt_r     <= {CNT_W{1'b0}};
                    err_vec_r <= {NUM_ERR{1'b0}};
                    err_idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign o_state     = state_r;
    assign o_busy      = flags_r[2];
    assign o_done      = flags_r[1];
    assign o_halt_req  = flags_r[0];
    assign o_cycle_cnt = cnt_r;
    assign o_err_vec   = err_vec_r;
    assign o_err_idx   = err_idx_r;
    assign o_run_cnt   = run_cnt_r;

endmodule

// File: tb/tb_wasm_run_monitor.sv
// Scoreboard bench for wasm_run_monitor: two configurations (32-bit counter with a 20-cycle
// watchdog, and a 4-bit counter with the watchdog disabled) share one stimulus stream.
module tb_wasm_run_monitor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       clear;
    logic       fin;
    logic [2:0] err;

    logic [2:0]  st0, st1;
    logic        busy0, busy1, done0, done1, halt0, halt1;
    logic [31:0] cnt0;
    logic [3:0]  cnt1;
    logic [2:0]  ev0, ev1;
    logic [1:0]  idx0, idx1;
    logic [7:0]  runs0, runs1;

    wasm_run_monitor #(.CNT_W(32), .TIMEOUT_CYCLES(20), .NUM_ERR(3), .RUN_CNT_W(8)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clear(clear),
        .i_instr_finish(fin), .i_err(err),
        .o_state(st0), .o_busy(busy0), .o_done(done0), .o_halt_req(halt0),
        .o_cycle_cnt(cnt0), .o_err_vec(ev0), .o_err_idx(idx0), .o_run_cnt(runs0)
    );

    wasm_run_monitor #(.CNT_W(4), .TIMEOUT_CYCLES(0), .NUM_ERR(3), .RUN_CNT_W(8)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_clear(clear),
        .i_instr_finish(fin), .i_err(err),
        .o_state(st1), .o_busy(busy1), .o_done(done1), .o_halt_req(halt1),
        .o_cycle_cnt(cnt1), .o_err_vec(ev1), .o_err_idx(idx1), .o_run_cnt(runs1)
    );

    typedef struct {
        int     st;
        longint cnt;
        int     errv;
        int     idx;
        int     runs;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: one run-supervisor per configuration, in plain integers.
    longint cfg_max[2] = '{64'd4294967295, 64'd15};
    int     cfg_to[2]  = '{20, 0};
    int     m_st[2];
    longint m_cnt[2];
    int     m_errv[2];
    int     m_idx[2];
    int     m_runs[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int first_set(input int v);
        for (int i = 0; i < 3; i++) begin
            if (((v >> i) & 1) == 1) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_st[c] = 0; m_cnt[c] = 0; m_errv[c] = 0; m_idx[c] = 0; m_runs[c] = 0;
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit cl, input bit f, input int e);
        if (!r) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            if (m_st[c] == 0) begin
                if (!cl && s) begin m_st[c] = 1; m_cnt[c] = 0; end
            end else if (m_st[c] == 1) begin
                if (cl) begin
                    m_st[c] = 0; m_cnt[c] = 0;
                end else if (e != 0) begin
                    m_st[c] = 3; m_errv[c] = e; m_idx[c] = first_set(e);
                    m_runs[c] = (m_runs[c] + 1) % 256;
                end else if (f) begin
                    m_st[c] = 2; m_runs[c] = (m_runs[c] + 1) % 256;
                end else if (cfg_to[c] != 0 && m_cnt[c] == cfg_to[c] - 1) begin
                    m_st[c] = 4; m_runs[c] = (m_runs[c] + 1) % 256;
                end else if (m_cnt[c] < cfg_max[c]) begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end else if (cl) begin
                m_st[c] = 0; m_cnt[c] = 0; m_errv[c] = 0; m_idx[c] = 0;
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            e.st = m_st[c]; e.cnt = m_cnt[c]; e.errv = m_errv[c];
            e.idx = m_idx[c]; e.runs = m_runs[c];
            if (c == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the next sample must show.
    task automatic step(input bit r, input bit s, input bit cl, input bit f, input logic [2:0] e);
        @(negedge clk);
        mon_en = 1'b1;
        if (rst_n === 1'b1 && !r) begin
            model_reset();
            push_expected();
        end
        model_edge(r, s, cl, f, int'(e));
        push_expected();
        start = s; clear = cl; fin = f; err = e;
        rst_n = r;
    endtask

    task automatic chk(input string name, input int d, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, d, $time, act, exp);
        end
    endtask

    task automatic compare(input int d, input exp_t e, input int st, input int b, input int dn,
                           input int h, input longint cnt, input int ev, input int ix, input int rc);
        chk("state", d, st, e.st);
        chk("busy", d, b, (e.st == 1) ? 1 : 0);
        chk("done", d, dn, (e.st == 2) ? 1 : 0);
        chk("halt_req", d, h, (e.st == 3 || e.st == 4) ? 1 : 0);
        chk("cycle_cnt", d, cnt, e.cnt);
        chk("err_vec", d, ev, e.errv);
        chk("err_idx", d, ix, e.idx);
        chk("run_cnt", d, rc, e.runs);
    endtask

    // Monitor: sample after every clock edge and every asynchronous reset assertion.
    always @(posedge clk or negedge rst_n) begin
        if (mon_en) begin
            #1;
            if (q0.size() == 0 || q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
            end else begin
                compare(0, q0.pop_front(), int'(st0), int'(busy0), int'(done0), int'(halt0),
                        longint'(cnt0), int'(ev0), int'(idx0), int'(runs0));
                compare(1, q1.pop_front(), int'(st1), int'(busy1), int'(done1), int'(halt1),
                        longint'(cnt1), int'(ev1), int'(idx1), int'(runs1));
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; fin = 1'b0; err = 3'b000;
        model_reset();
        step(0, 0, 0, 0, 3'b000);
        step(0, 0, 0, 0, 3'b000);

        // Finish on the 10th RUN edge, then sticky DONE and clear priority.
        step(1, 1, 0, 0, 3'b000);
        repeat (9) step(1, 0, 0, 0, 3'b000);
        step(1, 0, 0, 1, 3'b000);
        repeat (2) step(1, 1, 0, 0, 3'b000);
        step(1, 0, 1, 0, 3'b000);
        step(1, 1, 1, 0, 3'b000);
        step(1, 0, 0, 0, 3'b000);

        // Multi-bit error on the 5th RUN edge; later inputs ignored.
        step(1, 1, 0, 0, 3'b000);
        repeat (4) step(1, 0, 0, 0, 3'b000);
        step(1, 0, 0, 0, 3'b110);
        repeat (3) step(1, 1, 0, 1, 3'b011);
        step(1, 0, 1, 0, 3'b000);

        // Error and finish together on the 3rd RUN edge.
        step(1, 1, 0, 0, 3'b000);
        repeat (2) step(1, 0, 0, 0, 3'b000);
        step(1, 0, 0, 1, 3'b001);
        step(1, 0, 1, 0, 3'b000);

        // Watchdog on dut0, saturation on dut1, then late finish/error.
        step(1, 1, 0, 0, 3'b000);
        repeat (24) step(1, 0, 0, 0, 3'b000);
        step(1, 0, 0, 1, 3'b100);
        step(1, 0, 0, 1, 3'b010);
        step(1, 0, 1, 0, 3'b000);

        // Asynchronous reset mid-run, then a fresh run from zero.
        step(1, 1, 0, 0, 3'b000);
        repeat (7) step(1, 0, 0, 0, 3'b000);
        step(0, 0, 0, 0, 3'b000);
        step(0, 1, 0, 0, 3'b000);
        step(1, 1, 0, 0, 3'b000);
        repeat (3) step(1, 0, 0, 0, 3'b000);
        step(1, 0, 0, 1, 3'b000);
        step(1, 0, 1, 0, 3'b000);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            bit r, s, cl, f;
            logic [2:0] e;
            r  = ($urandom_range(0, 199) != 0);
            s  = ($urandom_range(0, 3) == 0);
            cl = ($urandom_range(0, 19) == 0);
            f  = ($urandom_range(0, 14) == 0);
            e  = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            step(r, s, cl, f, e);
        end
        step(1, 0, 0, 0, 3'b000);

        @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", q0.size() + q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wasm_run_monitor.md
Name: wasm_run_monitor

Overview:
- Synthesizable run supervisor that sits beside WASM_TOP and replaces ad-hoc bench logic for cycle counting and end-of-run detection.
- Counts clocks from a start pulse until the core's instruction-finish flag.
- Enforces a parametrised watchdog timeout and captures the first fault from N error channels (INSTR_ERROR, stack exceed, empty pop, ...).
- Exposes sticky status and a halt request for the core and for the benches.

Parameters:
CNT_W, 32, width of cycle counter and timeout compare
TIMEOUT_CYCLES, 500, watchdog limit in RUN cycles; 0 disables the watchdog
NUM_ERR, 3, number of error input channels (at least 1)
RUN_CNT_W, 8, width of the completed-run counter

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset
i_start  in  1  start-run pulse, honoured only in IDLE
i_clear  in  1  return to IDLE from any state
i_instr_finish  in  1  core finished program
i_err  in  NUM_ERR  error flags, level, bit 0 is highest priority
o_state  out  3  IDLE=0, RUN=1, DONE=2, FAULT=3, TIMEOUT=4
o_busy  out  1  state==RUN
o_done  out  1  state==DONE
o_halt_req  out  1  state is FAULT or TIMEOUT
o_cycle_cnt  out  CNT_W  RUN-cycle count; frozen in terminal states
o_err_vec  out  NUM_ERR  snapshot of i_err at the fault cycle
o_err_idx  out  clog2(NUM_ERR) max 1  index of lowest set bit of the snapshot
o_run_cnt  out  RUN_CNT_W  number of runs that reached DONE, FAULT or TIMEOUT

Behaviour:
- Reset is asynchronous and active-low on i_rst_n. Single clock i_clk; all state updates on the rising edge.
- Reset values: state=IDLE, cycle_cnt=0, err_vec=0, err_idx=0, run_cnt=0. All derived flags are 0.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- IDLE:
  - If i_clear=1, stay in IDLE.
  - Else if i_start=1, go to RUN and set cycle_cnt=0 at that edge.
  - i_clear has priority over i_start.
- RUN, evaluated each edge in this priority order:
  1. i_clear=1: go to IDLE; cycle_cnt=0; run_cnt unchanged.
  2. |i_err: go to FAULT; err_vec=i_err; err_idx=lowest set index; cycle_cnt holds.
  3. i_instr_finish=1: go to DONE; cycle_cnt holds.
  4. TIMEOUT_CYCLES!=0 and cycle_cnt==TIMEOUT_CYCLES-1: go to TIMEOUT; cycle_cnt holds.
  5. Otherwise cycle_cnt+1, saturating at all-ones; no wrap.
- Error and finish in the same cycle: FAULT wins.
- o_cycle_cnt in DONE equals the number of RUN cycles in which finish was 0.
  - Example: finish seen on the 1st RUN edge gives 0.
- run_cnt increments by 1, modulo 2^RUN_CNT_W, on every RUN to DONE, FAULT or TIMEOUT transition.
- DONE, FAULT and TIMEOUT are sticky.
  - i_start is ignored in these states.
  - i_err and i_instr_finish are ignored; err_vec does not update after capture.
  - i_clear returns to IDLE and zeroes cycle_cnt, err_vec and err_idx. run_cnt is retained.
- i_start in RUN is ignored; a run is not restarted.
- Reset asserted mid-run forces the reset values immediately, without waiting for a clock edge.
- Widths:
  - TIMEOUT_CYCLES compares at CNT_W bits.
  - A TIMEOUT_CYCLES value not representable in CNT_W is a parameter error. Flag it with an elaboration-time check.

Test Plan:
- Start, then finish asserted on the 10th RUN edge -> state=2, o_done=1, o_cycle_cnt=9, o_run_cnt=1, o_halt_req=0.
- i_err=3'b110 on the 5th RUN edge -> state=3, o_err_vec=110, o_err_idx=1, o_cycle_cnt=4, o_halt_req=1.
- i_err=3'b001 and finish together on the 3rd RUN edge -> FAULT, o_err_idx=0, o_cycle_cnt=2.
- TIMEOUT_CYCLES=20, no finish -> TIMEOUT after 20 RUN edges, o_cycle_cnt=19, o_halt_req=1. Later finish and i_err have no effect.
- Reset pulse while cycle_cnt=7 -> all outputs zero asynchronously, before the next edge. A subsequent start counts from 0.
- Sticky state and priority, in sequence:
  - DONE, then i_start -> stays DONE.
  - i_clear -> IDLE, o_run_cnt=1 kept.
  - i_clear and i_start together in IDLE -> stays IDLE.
  - Second full run -> o_run_cnt=2.
  - With TIMEOUT_CYCLES=0 and CNT_W=4, the counter saturates at 15 with no timeout.
